if_layer_controller: RTL and testbench

Controller for a layer of NUM_NEURONS if_neuron instances that share one weight-memory bus. It streams host weight words into each neuron's weight memory in a fixed order. It then runs an inference over a programmable number of timesteps: it resets the neurons, applies one input spike vector per timestep and counts output spikes per neuron. At the end it reports the winning neuron (argmax of spike counts) to the host.

---
 rtl/if_layer_controller.sv | 209 ++++++++++++++++++++
 tb/tb_if_layer_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_layer_controller.sv
// if_layer_controller
//   Drives a layer of NUM_NEURONS integrate-and-fire neurons that share one
//   weight-memory bus. Host weight words are streamed into the neuron memories
//   (neuron 0 addresses 0..NUM_INPUTS-1, then neuron 1, ...). An inference run
//   resets the neurons, applies one spike vector per timestep, counts output
//   spikes per neuron and finally reports the argmax neuron and its count.
//
// Ports
//   mem_clk, rst              clock, asynchronous active-low reset
//   load_start                begin weight load (IDLE only)
//   cfg_valid/cfg_ready/cfg_data   weight word stream
//   run_start, num_timesteps  begin inference with T timesteps (IDLE only)
//   spk_valid/spk_ready/spk_data   input spike vector stream
//   neuron_rst                reset pulse to all neurons
//   neuron_spike_in           spike vector broadcast to neurons
//   neuron_spike_out          per-neuron output spikes
//   w_addr, w_din, w_wen      shared weight-memory write bus, one-hot enable
//   busy                      high when not IDLE
//   done                      one-cycle pulse at the end of a run
//   winner, winner_count      argmax neuron index and its spike count
module if_layer_controller #(
    parameter int NUM_INPUTS        = 4,
    parameter int NUM_NEURONS       = 4,
    parameter int WEIGHT_SIZE       = 32,
    parameter int WEIGHT_ADDR_WIDTH = 2,
    parameter int NEURON_IDX_WIDTH  = 2,
    parameter int TS_WIDTH          = 16,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         mem_clk,
    input  logic                         rst,
    input  logic                         load_start,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [WEIGHT_SIZE-1:0]       cfg_data,
    input  logic                         run_start,
    input  logic [TS_WIDTH-1:0]          num_timesteps,
    input  logic                         spk_valid,
    output logic                         spk_ready,
    input  logic [NUM_INPUTS-1:0]        spk_data,
    output logic                         neuron_rst,
    output logic [NUM_INPUTS-1:0]        neuron_spike_in,
    input  logic [NUM_NEURONS-1:0]       neuron_spike_out,
    output logic [WEIGHT_ADDR_WIDTH-1:0] w_addr,
    output logic [WEIGHT_SIZE-1:0]       w_din,
    output logic [NUM_NEURONS-1:0]       w_wen,
    output logic                         busy,
    output logic                         done,
    output logic [NEURON_IDX_WIDTH-1:0]  winner,
    output logic [CNT_WIDTH-1:0]         winner_count
);

    typedef enum logic [2:0] {
        IDLE, LOAD, CLEAR, FETCH, APPLY, GAP, ARGMAX, DONE
    } state_t;

    localparam logic [WEIGHT_ADDR_WIDTH-1:0] LAST_ADDR   = WEIGHT_ADDR_WIDTH'(NUM_INPUTS - 1);
    localparam logic [NEURON_IDX_WIDTH-1:0]  LAST_NEURON = NEURON_IDX_WIDTH'(NUM_NEURONS - 1);

    state_t                        state, state_next;
    logic [WEIGHT_ADDR_WIDTH-1:0]  addr;
    logic [NEURON_IDX_WIDTH-1:0]   idx;
    logic [TS_WIDTH-1:0]           t_total;
    logic [TS_WIDTH-1:0]           ts_cnt;
    logic [TS_WIDTH-1:0]           ts_inc;
    logic [CNT_WIDTH-1:0]          spike_cnt [NUM_NEURONS];
    logic [NUM_INPUTS-1:0]         spike_vec;
    logic [NEURON_IDX_WIDTH-1:0]   scan;
    logic [NEURON_IDX_WIDTH-1:0]   best_idx, best_idx_next;
    logic [CNT_WIDTH-1:0]          best_cnt, best_cnt_next;
    logic                          cfg_fire;
    logic                          last_word;

    assign cfg_fire        = cfg_valid && (state == LOAD);
    assign last_word       = (idx == LAST_NEURON) && (addr == LAST_ADDR);
    assign ts_inc          = ts_cnt + TS_WIDTH'(1);
    assign w_addr          = addr;
    assign w_din           = cfg_data;
    assign neuron_spike_in = spike_vec;

    // Argmax step: strictly-greater replacement keeps the lowest index on ties
    always_comb begin
        best_idx_next = best_idx;
        best_cnt_next = best_cnt;
        if (spike_cnt[scan] > best_cnt) begin
            best_idx_next = scan;
            best_cnt_next = spike_cnt[scan];
        end
    end

    always_comb begin
        state_next = state;
        cfg_ready  = 1'b0;
        spk_ready  = 1'b0;
        neuron_rst = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        w_wen      = '0;
        case (state)
            IDLE: begin
                if (load_start)     state_next = LOAD;
                else if (run_start) state_next = CLEAR;
            end
            LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_fire) begin
                    w_wen = NUM_NEURONS'(1) << idx;
                    if (last_word) state_next = IDLE;
                end
            end
            CLEAR: begin
                neuron_rst = 1'b1;
                state_next = (t_total != '0) ? FETCH : ARGMAX;
            end
            FETCH: begin
                spk_ready = 1'b1;
                if (spk_valid) state_next = APPLY;
            end
            APPLY: state_next = GAP;
            GAP:   state_next = (ts_inc == t_total) ? ARGMAX : FETCH;
            ARGMAX: begin
                if (scan == LAST_NEURON) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge mem_clk or negedge rst) begin
        if (!rst) begin
            addr         <= '0;
            idx          <= '0;
            t_total      <= '0;
            ts_cnt       <= '0;
            spike_vec    <= '0;
            scan         <= '0;
            best_idx     <= '0;
            best_cnt     <= '0;
            winner       <= '0;
            winner_count <= '0;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                spike_cnt[i] <= '0;
            end
        end else begin
            // Vector is live only for the APPLY cycle; FETCH and GAP see zero
            spike_vec <= (state == FETCH && spk_valid) ? spk_data : '0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        addr <= '0;
                        idx  <= '0;
                    end else if (run_start) begin
                        t_total <= num_timesteps;
                    end
                end
                LOAD: begin
                    if (cfg_fire) begin
                        if (addr == LAST_ADDR) begin
                            addr <= '0;
                            idx  <= last_word ? '0 : idx + NEURON_IDX_WIDTH'(1);
                        end else begin
                            addr <= addr + WEIGHT_ADDR_WIDTH'(1);
                        end
                    end
                end
                CLEAR: begin
                    ts_cnt   <= '0;
                    scan     <= '0;
                    best_idx <= '0;
                    best_cnt <= '0;
                    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                        spike_cnt[i] <= '0;
                    end
                end
                APPLY: begin
                    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                        if (neuron_spike_out[i] && (spike_cnt[i] != '1)) begin
                            spike_cnt[i] <= spike_cnt[i] + CNT_WIDTH'(1);
                        end
                    end
                end
                GAP: ts_cnt <= ts_inc;
                ARGMAX: begin
                    best_idx <= best_idx_next;
                    best_cnt <= best_cnt_next;
                    scan     <= scan + NEURON_IDX_WIDTH'(1);
                    // Publish on the last scan step so results are visible during DONE
                    if (scan == LAST_NEURON) begin
                        winner       <= best_idx_next;
                        winner_count <= best_cnt_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_layer_controller.sv
// Directed bench for if_layer_controller with a behavioural neuron stand-in:
// neurons emit a programmable spike pattern whenever the broadcast vector is
// non-zero (i.e. during APPLY).
module tb_if_layer_controller;

    logic        mem_clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;
    logic        run_start;
    logic [15:0] num_timesteps;
    logic        spk_valid;
    logic        spk_ready;
    logic [3:0]  spk_data;
    logic        neuron_rst;
    logic [3:0]  neuron_spike_in;
    logic [3:0]  neuron_spike_out;
    logic [1:0]  w_addr;
    logic [31:0] w_din;
    logic [3:0]  w_wen;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic [15:0] winner_count;

    logic [3:0]  pattern;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 mem_clk = ~mem_clk;

    assign neuron_spike_out = (neuron_spike_in != 4'b0000) ? pattern : 4'b0000;

    if_layer_controller #(
        .NUM_INPUTS       (4),
        .NUM_NEURONS      (4),
        .WEIGHT_SIZE      (32),
        .WEIGHT_ADDR_WIDTH(2),
        .NEURON_IDX_WIDTH (2),
        .TS_WIDTH         (16),
        .CNT_WIDTH        (16)
    ) dut (
        .mem_clk         (mem_clk),
        .rst             (rst),
        .load_start      (load_start),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_data        (cfg_data),
        .run_start       (run_start),
        .num_timesteps   (num_timesteps),
        .spk_valid       (spk_valid),
        .spk_ready       (spk_ready),
        .spk_data        (spk_data),
        .neuron_rst      (neuron_rst),
        .neuron_spike_in (neuron_spike_in),
        .neuron_spike_out(neuron_spike_out),
        .w_addr          (w_addr),
        .w_din           (w_din),
        .w_wen           (w_wen),
        .busy            (busy),
        .done            (done),
        .winner          (winner),
        .winner_count    (winner_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_done"},       done, 0);
        check({tag, "_cfg_ready"},  cfg_ready, 0);
        check({tag, "_spk_ready"},  spk_ready, 0);
        check({tag, "_neuron_rst"}, neuron_rst, 0);
        check({tag, "_spike_in"},   neuron_spike_in, 0);
        check({tag, "_w_wen"},      w_wen, 0);
        check({tag, "_winner"},     winner, 0);
        check({tag, "_win_cnt"},    winner_count, 0);
    endtask

    // Load 16 words valued 0..15 with cfg_valid toggling; also_run raises
    // run_start together with load_start, which must be ignored.
    task automatic load_weights(input logic also_run);
        int k;
        int rst_seen;
        @(posedge mem_clk); #1;
        load_start = 1'b1;
        run_start  = also_run;
        num_timesteps = 16'd2;
        @(posedge mem_clk); #1;
        load_start = 1'b0;
        run_start  = 1'b0;
        k = 0;
        rst_seen = 0;
        for (int c = 1; c < 100 && k < 16; c++) begin
            cfg_valid = (c % 2 == 1);
            cfg_data  = k;
            @(negedge mem_clk);
            if (neuron_rst) rst_seen++;
            if (c == 1) check("load_busy", busy, 1);
            if (cfg_valid) begin
                check("load_ready", cfg_ready, 1);
                check("load_wen",   w_wen, 32'(4'b0001 << (k / 4)));
                check("load_addr",  w_addr, k % 4);
                check("load_din",   w_din, k);
                k++;
            end else begin
                check("load_idle_wen", w_wen, 0);
            end
            @(posedge mem_clk); #1;
        end
        check("load_words", k, 16);
        check("load_no_run", rst_seen, 0);
        cfg_valid = 1'b1;
        cfg_data  = 32'd99;
        @(negedge mem_clk);
        check("load_end_busy",  busy, 0);
        check("load_end_ready", cfg_ready, 0);
        check("load_end_wen",   w_wen, 0);
        @(posedge mem_clk); #1;
        cfg_valid = 1'b0;
        @(negedge mem_clk);
        check("load_no_run_busy", busy, 0);
    endtask

    // Run with T timesteps; spk_valid withheld for `stall` FETCH cycles at the first step.
    task automatic do_run(input int t, input logic [3:0] pat, input int stall,
                          input int exp_done, input int exp_win, input int exp_cnt);
        int cyc, done_cyc, rst_pulses, rst_cyc, active;
        pattern  = pat;
        spk_data = 4'b1111;
        @(posedge mem_clk); #1;
        run_start     = 1'b1;
        num_timesteps = 16'(t);
        spk_valid     = (stall == 0);
        cyc = 0; done_cyc = -1; rst_pulses = 0; rst_cyc = -1; active = 0;
        while (cyc < 300 && done_cyc < 0) begin
            @(negedge mem_clk);
            if (neuron_rst) begin
                rst_pulses++;
                if (rst_cyc < 0) rst_cyc = cyc;
            end
            if (neuron_spike_in != 4'b0000) active++;
            if (stall > 0 && cyc >= 2 && cyc < 2 + stall) begin
                check("stall_spk_ready", spk_ready, 1);
                check("stall_spike_in",  neuron_spike_in, 0);
            end
            if (done) begin
                done_cyc = cyc;
                check("winner",       winner, exp_win);
                check("winner_count", winner_count, exp_cnt);
            end
            @(posedge mem_clk); #1;
            run_start = 1'b0;
            cyc++;
            if (cyc == 2 + stall) spk_valid = 1'b1;
        end
        check("done_cycle",  done_cyc, exp_done);
        check("rst_pulses",  rst_pulses, 1);
        check("rst_cycle",   rst_cyc, 1);
        check("apply_count", active, t);
        @(negedge mem_clk);
        check("done_pulse", done, 0);
        check("idle_busy",  busy, 0);
        check("hold_winner", winner, exp_win);
        spk_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        load_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        run_start = 1'b0; num_timesteps = '0;
        spk_valid = 1'b0; spk_data = '0; pattern = '0;
        repeat (2) @(posedge mem_clk);
        @(negedge mem_clk);
        check_all_zero("reset");
        rst = 1'b1;

        load_weights(1'b0);
        do_run(4, 4'b0100, 0, 18, 2, 4);
        do_run(2, 4'b0010, 5, 17, 1, 2);
        do_run(0, 4'b1111, 0, 6, 0, 0);
        load_weights(1'b1);
        do_run(3, 4'b1010, 0, 15, 1, 3);

        // Reset in the FETCH cycle of timestep 2 of a T=4 run
        pattern   = 4'b0001;
        spk_data  = 4'b1111;
        spk_valid = 1'b1;
        @(posedge mem_clk); #1;
        run_start = 1'b1;
        num_timesteps = 16'd4;
        @(posedge mem_clk); #1;
        run_start = 1'b0;
        repeat (7) @(posedge mem_clk);
        #1;
        check("pre_rst_busy", busy, 1);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge mem_clk); #1;
        rst = 1'b1;
        spk_valid = 1'b0;
        do_run(2, 4'b1000, 0, 12, 3, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
